pipelined_segment_adder: RTL and testbench

//  Parametrised successor to the fixed-width adder tree: WIDTH-bit add/subtract split into SEG_W-bit

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_segment.sv | 17 +
 rtl/pipelined_segment_adder.sv | 115 +++++++++++
 tb/tb_pipelined_segment_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// Optional flag outputs are enabled by defining PIPE_ADDER_FLAGS_EN.
package adder_pkg;

    localparam int SEG_W_DEF = 8;
    localparam int WIDTH_DEF = 32;

    function automatic int num_seg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG_W-bit slice: a + b + cin with carry out and signed-overflow flag.
// The overflow flag is only meaningful on the most-significant slice.
module adder_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
    assign ovf = (a[SEG_W-1] == b[SEG_W-1]) && (sum[SEG_W-1] != a[SEG_W-1]);

endmodule

// File: rtl/pipelined_segment_adder.sv
// WIDTH-bit add/sub, one SEG_W segment per stage, global-stall handshake.
// Define PIPE_ADDER_FLAGS_EN to add out_cout / out_ovf.
module pipelined_segment_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             out_cout,
    output logic             out_ovf
`endif
);

    localparam int N = num_seg(WIDTH, SEG_W);

    // a_hi/b_hi shift right each stage so the next segment sits at bit 0;
    // sum_lo shifts right with each new segment entering at the top.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
    } stage_t;

    stage_t           st_d [N];
    stage_t           st_q [N];
    logic [SEG_W-1:0] seg_sum [N];
    logic [N-1:0]     seg_cout;
    logic [N-1:0]     seg_ovf;
    logic             advance;

    if (WIDTH % SEG_W != 0) begin : g_bad_cfg
        $error("WIDTH must be a multiple of SEG_W");
    end

    assign advance  = !st_q[N-1].valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        st_d[0].valid  = in_valid;
        st_d[0].carry  = in_sub ? 1'b1 : in_cin;
        st_d[0].sum_lo = '0;
        st_d[0].a_hi   = in_a;
        st_d[0].b_hi   = in_sub ? ~in_b : in_b;
        for (int k = 1; k < N; k++) begin
            st_d[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_seg
        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a    (st_d[k].a_hi[SEG_W-1:0]),
            .b    (st_d[k].b_hi[SEG_W-1:0]),
            .cin  (st_d[k].carry),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k]),
            .ovf  (seg_ovf[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                st_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < N; k++) begin
                st_q[k].valid  <= st_d[k].valid;
                st_q[k].carry  <= seg_cout[k];
                st_q[k].sum_lo <= (st_d[k].sum_lo >> SEG_W)
                                | (WIDTH'(seg_sum[k]) << (WIDTH - SEG_W));
                st_q[k].a_hi   <= st_d[k].a_hi >> SEG_W;
                st_q[k].b_hi   <= st_d[k].b_hi >> SEG_W;
            end
        end
    end

    assign out_valid = st_q[N-1].valid;
    assign out_sum   = st_q[N-1].sum_lo;

`ifdef PIPE_ADDER_FLAGS_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= seg_ovf[N-1];
        end
    end

    assign out_cout = st_q[N-1].carry;
    assign out_ovf  = ovf_q;
`endif

    // Last-stage operand remnants and lower-slice ovf flags have no consumer.
    logic unused_bits;
    assign unused_bits = ^{st_q[N-1].a_hi, st_q[N-1].b_hi,
                           st_q[N-1].carry, seg_ovf};

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder (WIDTH=32, SEG_W=8).
// Flag outputs are checked when PIPE_ADDER_FLAGS_EN is defined.
module tb_pipelined_segment_adder;

    localparam int W  = 32;
    localparam int SW = 8;
    localparam int NS = W / SW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
`ifdef PIPE_ADDER_FLAGS_EN
    logic         out_cout;
    logic         out_ovf;
`endif

    pipelined_segment_adder #(.WIDTH(W), .SEG_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef PIPE_ADDER_FLAGS_EN
        ,
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           popped = 0;
    int           accepted = 0;
    logic         lat_chk = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   r;
        be = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        e.acc  = 0;
        return e;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic ordy,
                        input exp_t ex);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, prev_sum);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                popped++;
                check("sum", out_sum, e.sum);
`ifdef PIPE_ADDER_FLAGS_EN
                check("cout", out_cout, e.cout);
                check("ovf", out_ovf, e.ovf);
`endif
                if (lat_chk) check("latency", cyc - e.acc, NS);
            end
        end
        if (v && in_ready) begin
            e = ex;
            e.acc = cyc;
            sb.push_back(e);
            accepted++;
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = out_sum;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, model('0, '0, 1'b0, 1'b0));
    endtask

    task automatic drain();
        for (int i = 0; i < 8 * NS + 20 && sb.size() != 0; i++) idle(1'b1);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum  = s;
        e.cout = co;
        e.ovf  = ov;
        e.acc  = 0;
        step(1'b1, a, b, cin, sub, 1'b1, e);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_ready", in_ready, 1);
`ifdef PIPE_ADDER_FLAGS_EN
        check("rst_cout", out_cout, 0);
        check("rst_ovf", out_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        lat_chk = 1'b1;
        directed(32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        directed(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed(32'hA, 32'h3, 1'b1, 1'b1, 32'h7, 1'b1, 1'b0);
        directed(32'h00FF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        lat_chk = 1'b0;

        popped   = 0;
        accepted = 0;
        for (int g = 0; g < 2000 && accepted < 100; g++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            logic         s;
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            step(1'b1, a, b, c, s, 1'($urandom_range(1)), model(a, b, c, s));
        end
        drain();
        check("stream_in", accepted, 100);
        check("stream_out", popped, 100);

        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] a;
            a = $urandom;
            step(1'b1, a, 32'h1, 1'b0, 1'b0, 1'b1, model(a, 32'h1, 1'b0, 1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_sum", out_sum, 0);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * NS; i++) begin
            @(negedge clk);
            #1;
            check("stale_out", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
